// File: rtl/spi_target.sv
// spi_target: SPI mode 0 target (peripheral side), MSB first, 8-bit frames,
// on the native PicoRV32 memory bus. SCK, CS_N and MOSI are oversampled
// in the clk domain.
//
// Optional build macro: SPI_TARGET_RXFIFO_EN
//   defined   -> 4-entry RX FIFO
//   undefined -> single RX holding register
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb/ready/rdata   PicoRV32 native bus target
//                       0x0 RX pop / TX write, 0x4 status (W1C), 0x8 fill
//   sck, cs_n, mosi     asynchronous SPI pins from the controller
//   miso, miso_oe       SPI data to the controller and its pad enable
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | deselected; miso_oe low, bit counter held at zero
// ST_SELECT | one cycle after CS_N falls; loads the first TX byte
// ST_SHIFT  | selected; SCK rise samples MOSI, SCK fall advances MISO
module spi_target (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   input  logic        sck,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe
);

   typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_SHIFT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  sck_q, cs_q;
   logic [1:0]  mosi_q;
   logic [2:0]  bit_cnt;
   logic [7:0]  rx_shift, tx_shift, tx_hold, fill;
   logic        tx_full, overrun, underrun;
   logic        load_tx, shift_tx, rx_edge;
   logic        rx_valid, rx_full;
   logic [7:0]  rx_head;
   logic [31:0] rdata_mux;

   // Two flops of synchronisation; the third flop only feeds edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q  <= 3'b000;
         cs_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], sck};
         cs_q   <= {cs_q[1:0], cs_n};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_sync;
   assign sck_rise  = sck_q[1] & ~sck_q[2];
   assign sck_fall  = ~sck_q[1] & sck_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign mosi_sync = mosi_q[1];

   logic selected;
   assign selected = (state_q != ST_IDLE);

   always_comb begin
      state_d  = state_q;
      load_tx  = 1'b0;
      shift_tx = 1'b0;
      rx_edge  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SHIFT;
               load_tx = 1'b1;
               rx_edge = sck_rise;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
            end else begin
               rx_edge = sck_rise;
               if (sck_fall) begin
                  if (bit_cnt == 3'd0) load_tx  = 1'b1;
                  else                 shift_tx = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus decode
   logic accept, is_wr, a_data, a_stat, a_fill;
   logic cpu_pop, wr_tx, wr_stat, wr_fill;
   assign accept  = mem_valid & ~mem_ready;
   assign is_wr   = |mem_wstrb;
   assign a_data  = (mem_addr[3:0] == 4'h0);
   assign a_stat  = (mem_addr[3:0] == 4'h4);
   assign a_fill  = (mem_addr[3:0] == 4'h8);
   assign cpu_pop = accept & ~is_wr & a_data & rx_valid;
   assign wr_tx   = accept & is_wr & a_data & ~tx_full;
   assign wr_stat = accept & is_wr & a_stat;
   assign wr_fill = accept & is_wr & a_fill;

   logic unused_bus;
   assign unused_bus = ^{mem_addr[31:4], mem_wdata[31:8]};

   logic [7:0] rx_byte, tx_next;
   logic       rx_push, push_ok, push_drop;
   assign rx_byte   = {rx_shift[6:0], mosi_sync};
   assign rx_push   = rx_edge & (bit_cnt == 3'd7);
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok   = rx_push & (~rx_full | cpu_pop);
   assign push_drop = rx_push & ~push_ok;
   assign tx_next   = tx_full ? tx_hold : fill;

`ifdef SPI_TARGET_RXFIFO_EN
   logic [7:0] fifo_mem [0:3];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   assign rx_valid = (count != 3'd0);
   assign rx_full  = (count == 3'd4);
   assign rx_head  = fifo_mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= rx_byte;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (cpu_pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push_ok} - {2'b00, cpu_pop};
      end
   end
`else
   logic [7:0] rx_hold;
   logic       rx_hold_vld;
   assign rx_valid = rx_hold_vld;
   assign rx_full  = rx_hold_vld;
   assign rx_head  = rx_hold;
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_hold     <= 8'h00;
         rx_hold_vld <= 1'b0;
      end else if (push_ok) begin
         rx_hold     <= rx_byte;
         rx_hold_vld <= 1'b1;
      end else if (cpu_pop) begin
         rx_hold_vld <= 1'b0;
      end
   end
`endif

   always_comb begin
      rdata_mux = 32'h0;
      if (!is_wr) begin
         case (mem_addr[3:0])
            4'h0:    rdata_mux = {24'h0, rx_valid ? rx_head : 8'h00};
            4'h4:    rdata_mux = {27'h0, underrun, selected, overrun, tx_full, rx_valid};
            4'h8:    rdata_mux = {24'h0, fill};
            default: rdata_mux = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt   <= 3'd0;
         rx_shift  <= 8'h00;
         tx_shift  <= 8'h00;
         tx_hold   <= 8'h00;
         tx_full   <= 1'b0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
         fill      <= 8'hFF;
         miso      <= 1'b1;
         miso_oe   <= 1'b0;
         mem_ready <= 1'b0;
         mem_rdata <= 32'h0;
      end else begin
         state_q <= state_d;

         if (state_d == ST_IDLE) begin
            bit_cnt <= 3'd0;
            miso_oe <= 1'b0;
         end else begin
            if (load_tx) miso_oe <= 1'b1;
            if (rx_edge) begin
               rx_shift <= rx_byte;
               bit_cnt  <= bit_cnt + 3'd1;
            end
         end

         if (load_tx) begin
            tx_shift <= tx_next;
            miso     <= tx_next[7];
         end else if (shift_tx) begin
            tx_shift <= {tx_shift[6:0], 1'b1};
            miso     <= tx_shift[6];
         end

         // A load uses the holding state from before this cycle's write.
         if (wr_tx) begin
            tx_hold <= mem_wdata[7:0];
            tx_full <= 1'b1;
         end else if (load_tx) begin
            tx_full <= 1'b0;
         end

         if (push_drop)                   overrun <= 1'b1;
         else if (wr_stat && mem_wdata[2]) overrun <= 1'b0;

         if (load_tx && !tx_full)          underrun <= 1'b1;
         else if (wr_stat && mem_wdata[4]) underrun <= 1'b0;

         if (wr_fill) fill <= mem_wdata[7:0];

         mem_ready <= accept;
         mem_rdata <= accept ? rdata_mux : 32'h0;
      end
   end

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        sck = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        miso_oe;

   int checks = 0;
   int errors = 0;

   spi_target dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .sck       (sck),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready;
      int n = 0;
      tick(1);
      while (mem_ready !== 1'b1 && n < 8) begin
         tick(1);
         n++;
      end
      if (mem_ready !== 1'b1) check("bus_ready_timeout", 32'(mem_ready), 32'h1);
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wstrb = 4'h0;
      wait_ready();
      d = mem_rdata;
      mem_valid = 1'b0;
      tick(1);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      check(tag, d, exp);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = 4'hF;
      wait_ready();
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      tick(1);
   endtask

   // Controller side: SCK half period is 8 clk cycles. MOSI changes with
   // SCK low, MISO is sampled just before each rise. CS_N is released with
   // SCK still high so no trailing fall is seen while selected.
   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx   = 8'h00;
      cs_n = 1'b0;
      tick(8);
      check("miso_oe_selected", 32'(miso_oe), 32'h1);
      for (int i = 0; i < nbits; i++) begin
         if (i > 0) sck = 1'b0;
         mosi = tx[7-i];
         tick(8);
         rx  = {rx[6:0], miso};
         sck = 1'b1;
         tick(8);
      end
      cs_n = 1'b1;
      tick(4);
      check("miso_oe_deselect", 32'(miso_oe), 32'h0);
      sck = 1'b0;
      tick(8);
   endtask

   initial begin
      logic [7:0] rxb;

      // Reset values
      tick(4);
      check("rst_miso_oe", 32'(miso_oe), 32'h0);
      check("rst_miso", 32'(miso), 32'h1);
      check("rst_mem_ready", 32'(mem_ready), 32'h0);
      check("rst_mem_rdata", mem_rdata, 32'h0);
      reset = 1'b0;
      tick(2);
      rd_chk("rst_status", 32'h4, 32'h00);
      rd_chk("rst_fill", 32'h8, 32'hFF);
      rd_chk("unmapped_rd", 32'hC, 32'h0);
      rd_chk("empty_rx", 32'h0, 32'h0);

      // mem_ready is a single-cycle pulse even with mem_valid held
      mem_valid = 1'b1;
      mem_addr  = 32'h4;
      mem_wstrb = 4'h0;
      tick(1);
      check("ready_pulse", 32'(mem_ready), 32'h1);
      tick(1);
      check("ready_not_b2b", 32'(mem_ready), 32'h0);
      mem_valid = 1'b0;
      tick(1);

      // TX byte provided by the CPU
      bus_wr(32'h0, 32'h3C);
      rd_chk("status_tx_full", 32'h4, 32'h02);
      spi_xfer(8'hA5, 8, rxb);
      check("ctrl_rx_3c", 32'(rxb), 32'h3C);
      rd_chk("status_rx_valid", 32'h4, 32'h01);
      rd_chk("rx_a5", 32'h0, 32'hA5);
      rd_chk("status_after_pop", 32'h4, 32'h00);

      // No TX byte: fill is sent and underrun is flagged
      spi_xfer(8'h5A, 8, rxb);
      check("ctrl_rx_fill_ff", 32'(rxb), 32'hFF);
      rd_chk("status_underrun", 32'h4, 32'h11);
      rd_chk("rx_5a", 32'h0, 32'h5A);
      bus_wr(32'h4, 32'h10);
      rd_chk("underrun_w1c", 32'h4, 32'h00);

      bus_wr(32'h8, 32'hC3);
      rd_chk("fill_rw", 32'h8, 32'hC3);
      spi_xfer(8'h3E, 8, rxb);
      check("ctrl_rx_fill_c3", 32'(rxb), 32'hC3);
      rd_chk("rx_3e", 32'h0, 32'h3E);
      bus_wr(32'h8, 32'hFF);
      bus_wr(32'h4, 32'h10);
      bus_wr(32'hC, 32'hFFFF_FFFF);
      rd_chk("unmapped_wr_ignored", 32'h4, 32'h00);

      // Overrun
`ifdef SPI_TARGET_RXFIFO_EN
      for (int k = 1; k <= 5; k++) spi_xfer(8'(k * 17), 8, rxb);
      rd_chk("status_overrun", 32'h4, 32'h15);
      rd_chk("fifo_rd0", 32'h0, 32'h11);
      rd_chk("fifo_rd1", 32'h0, 32'h22);
      rd_chk("fifo_rd2", 32'h0, 32'h33);
      rd_chk("fifo_rd3", 32'h0, 32'h44);
      rd_chk("fifo_empty", 32'h0, 32'h00);
`else
      spi_xfer(8'h11, 8, rxb);
      spi_xfer(8'h22, 8, rxb);
      rd_chk("status_overrun", 32'h4, 32'h15);
      rd_chk("hold_rd0", 32'h0, 32'h11);
      rd_chk("hold_empty", 32'h0, 32'h00);
`endif
      bus_wr(32'h4, 32'h14);
      rd_chk("overrun_w1c", 32'h4, 32'h00);

      // Selected flag while CS_N is low (select load also flags underrun)
      cs_n = 1'b0;
      tick(8);
      rd_chk("status_selected", 32'h4, 32'h18);
      cs_n = 1'b1;
      tick(8);
      bus_wr(32'h4, 32'h10);

      // Aborted partial byte is discarded
      spi_xfer(8'hF0, 4, rxb);
      spi_xfer(8'h81, 8, rxb);
      check("ctrl_rx_after_abort", 32'(rxb), 32'hFF);
      rd_chk("rx_81", 32'h0, 32'h81);
      rd_chk("rx_only_one", 32'h0, 32'h00);
      bus_wr(32'h4, 32'h10);

      // Reset in the middle of a byte
      bus_wr(32'h0, 32'h77);
      bus_wr(32'h8, 32'h5A);
      cs_n = 1'b0;
      tick(8);
      mosi = 1'b1;
      tick(8);
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(4);
      reset = 1'b1;
      tick(2);
      check("midrst_miso_oe", 32'(miso_oe), 32'h0);
      check("midrst_miso", 32'(miso), 32'h1);
      check("midrst_mem_ready", 32'(mem_ready), 32'h0);
      cs_n = 1'b1;
      mosi = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(8);
      rd_chk("midrst_status", 32'h4, 32'h00);
      rd_chk("midrst_fill", 32'h8, 32'hFF);
      spi_xfer(8'h6C, 8, rxb);
      check("ctrl_rx_after_rst", 32'(rxb), 32'hFF);
      rd_chk("rx_6c", 32'h0, 32'h6C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral-side) block for the PicoRV32 SoC: it lets the CPU act as the device on an SPI bus driven by an external controller. It uses SPI mode 0, MSB first, with 8-bit frames. The block oversamples the external SCK, CS_N and MOSI in the `clk` domain and exposes RX data, TX data, status and fill-byte registers on the native PicoRV32 memory bus. It is the counterpart of the SoC's SPI controller and can be wired back-to-back with it for loopback tests.

## Interface
- Parameters: none.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_valid` in 1: bus request.
- `mem_addr` in 32: byte address; only [3:0] is decoded.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: any bit set means write, zero means read.
- `mem_ready` out 1: one-cycle acknowledge.
- `mem_rdata` out 32: read data, valid while `mem_ready` is high.
- `sck` in 1: external SPI clock, asynchronous.
- `cs_n` in 1: external chip select, active low, asynchronous.
- `mosi` in 1: data from the controller, asynchronous.
- `miso` out 1: data to the controller.
- `miso_oe` out 1: output enable for the `miso` pad; high only while selected.

## Operation
- **Input sync:** `sck`, `cs_n` and `mosi` each pass through 2 flops, plus a third flop on `sck` and `cs_n` for edge detection. Rise, fall, select and deselect are single-cycle strobes.
- **States:**
  - IDLE. Entered from reset and on every deselect. Sets `miso_oe`=0 and `bit_cnt`=0; the partial RX byte is discarded.
  - SELECT. Entered on a `cs_n` falling strobe. Loads `tx_shift` from `tx_hold` if `tx_full`, otherwise from `fill`. In the `fill` case it also sets `underrun`. Clears `tx_full` and drives `miso`=`tx_shift[7]`, `miso_oe`=1.
  - SHIFT.
- **SCK rise while selected:**
  - `rx_shift` <= {`rx_shift[6:0]`, `mosi_sync`}; `bit_cnt` increments, 3 bits wide and wrapping.
  - When `bit_cnt`==7, the completed byte is pushed to RX storage. If storage is full, the byte is dropped and `overrun` is set.
- **SCK fall while selected:**
  - If `bit_cnt`==0 (byte boundary), load the next TX byte with the same `tx_hold`/`fill`/`underrun` rule as SELECT.
  - Otherwise `tx_shift` <= {`tx_shift[6:0]`, 1}.
  - In both cases `miso` <= the new `tx_shift[7]`.
- **SCK edges while deselected:** ignored.
- **Register map** (the bus accepts when `mem_valid && !mem_ready`; every access, including unmapped ones, gets `mem_ready` the next cycle):
  - 0x0 read: returns {24'b0, RX head} and pops it. If RX storage is empty, returns 0 and changes no state.
  - 0x0 write: `tx_hold` <= `wdata[7:0]`, `tx_full`=1. Ignored if `tx_full` is already 1.
  - 0x4 read: {27'b0, `underrun`, `selected`, `overrun`, `tx_full`, `rx_valid`}.
  - 0x4 write: write-1-to-clear. Bit 2 clears `overrun`; bit 4 clears `underrun`.
  - 0x8: `fill` byte, read/write, 8 bits. Reset value 0xFF.
  - Other addresses: reads return 0, writes are ignored.
- **Simultaneous events:**
  - RX push and CPU pop in the same cycle: both take effect; no overrun if storage was full before the pop.
  - TX load and CPU write to 0x0 in the same cycle: the load uses the old `tx_hold` state; the write lands for the next byte.
  - Flag set and W1C in the same cycle: set wins.
- **Reset:** `mem_ready`=0, `mem_rdata`=0, `miso`=1, `miso_oe`=0. RX storage is emptied. `tx_full`, `overrun` and `underrun` are 0, `fill`=0xFF, shift registers are 0 and the FSM is in IDLE. A reset asserted mid-frame aborts the frame immediately.

## Timing
- `f_sck` ≤ `f_clk`/8.
- Pin edge to internal strobe: 3 `clk` cycles.
- `miso` change after SCK fall at the pin: ≤ 4 `clk` cycles. Same after CS_N fall, for the first bit.
- RX byte is visible in `rx_valid` 4 cycles after the 8th SCK rise.
- Bus latency: `mem_ready` 1 cycle after acceptance, never 2 consecutive cycles; `mem_rdata` is registered.

## Configuration
- `SPI_TARGET_RXFIFO_EN` defined:
  - RX storage is a 4-entry FIFO with wrapping 2-bit read/write pointers and a 3-bit count.
  - `rx_valid` = count != 0.
  - Overrun occurs when a 5th byte arrives unread.
- `SPI_TARGET_RXFIFO_EN` undefined:
  - RX storage is a single holding register.
  - Overrun occurs when a 2nd byte arrives before the first is read.

## Test plan
- Reset; read 0x4 -> 0x00000000; read 0x8 -> 0x000000FF; `miso_oe`=0.
- Write 0x0=0x3C; controller selects and clocks MOSI 0xA5 -> controller receives 0x3C; read 0x0 -> 0xA5; `underrun`=0.
- No TX write; select and clock one byte -> controller receives 0xFF; status bit 4 set; write 0x4=0x10 -> bit 4 clears.
- Clock 0x11, 0x22 unread (FIFO off) or 0x11–0x55 (FIFO on) -> `overrun`=1; reads return 0x11 (FIFO off) or 0x11, 0x22, 0x33, 0x44 (FIFO on), then 0.
- Deassert CS_N after 4 bits of 0xF0, then send a full 0x81 -> only 0x81 is received; `miso_oe` drops within 4 cycles of deselect.
- Assert `reset` mid-byte -> all outputs return to reset values; the next full frame is received correctly.
